// File: rtl/neo_linebuf_wr.sv
// -----------------------------------------------------------------------------
// neo_linebuf_wr
//
// Sprite line-buffer write stage. Pixel pairs from the graphics mux are tagged
// with the current strip palette. They are written into the draw buffer of a
// ping-pong pair at an auto-incrementing X position. The other (display)
// buffer is read out in parallel. LINE_START swaps the two roles.
//
// Optional feature (macro NEO_LINEBUF_CLEAR_EN):
//   When defined, every display read also writes zero to the same display
//   address (clear-after-read). Each buffer is then blank when it returns to
//   draw duty. When undefined, reads never modify the display buffer.
//
// Parameters:
//   XW            X address width (2^XW entries per buffer), XW >= 2
//   PW            palette index width (entry is {palette, 4-bit index})
//
// Ports:
//   CLK           system clock
//   RST           synchronous active-high reset
//   CLK_EN_12M_N  pixel-pair enable, active low (at most every other CLK)
//   LINE_START    one-CLK pulse, swaps draw/display buffers
//   LOAD          one-CLK pulse, latches X_START/PAL for a new sprite strip
//   X_START       first X of the strip
//   PAL           palette of the strip
//   WR_EN         pixel pair on GAD/GBD valid in this enabled cycle
//   GAD, GBD      pixel indices (A at X, B at X+1)
//   DOTA, DOTB    pixel A/B opaque; transparent pixels are never written
//   RD_EN         display read request
//   RD_ADDR       display read address
//   RD_DATA       registered {palette, index} from the display buffer
//   DRAW_SEL      buffer being drawn; the display buffer is ~DRAW_SEL
// -----------------------------------------------------------------------------
module neo_linebuf_wr #(
  parameter int XW = 9,
  parameter int PW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLK_EN_12M_N,
  input  logic          LINE_START,
  input  logic          LOAD,
  input  logic [XW-1:0] X_START,
  input  logic [PW-1:0] PAL,
  input  logic          WR_EN,
  input  logic [3:0]    GAD,
  input  logic [3:0]    GBD,
  input  logic          DOTA,
  input  logic          DOTB,
  input  logic          RD_EN,
  input  logic [XW-1:0] RD_ADDR,
  output logic [PW+3:0] RD_DATA,
  output logic          DRAW_SEL
);

  localparam int DW    = PW + 4;
  localparam int DEPTH = 1 << XW;

  localparam logic [XW-1:0] X_ONE = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [XW-1:0] X_TWO = {{(XW-2){1'b0}}, 2'b10};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WRB  = 1'b1
  } state_t;

  // Ping-pong line buffers (contents are not reset)
  logic [DW-1:0] buf0_r [DEPTH];
  logic [DW-1:0] buf1_r [DEPTH];

  state_t        state_r;
  state_t        state_nxt_s;

  logic [XW-1:0] x_r;
  logic [PW-1:0] pal_r;
  logic          draw_sel_r;

  // Pixel B is held for one CLK together with the buffer chosen at A time
  logic [XW-1:0] b_addr_r;
  logic [DW-1:0] b_data_r;
  logic          b_dot_r;
  logic          b_sel_r;

  logic          pair_go_s;
  logic [XW-1:0] a_addr_s;
  logic [PW-1:0] a_pal_s;

  logic          wr_en_s;
  logic          wr_sel_s;
  logic [XW-1:0] wr_addr_s;
  logic [DW-1:0] wr_data_s;
  logic          clr_en_s;

  assign pair_go_s = ~CLK_EN_12M_N & WR_EN & (state_r == ST_IDLE);
  assign DRAW_SEL  = draw_sel_r;

`ifdef NEO_LINEBUF_CLEAR_EN
  assign clr_en_s = RD_EN & ~RST;
`else
  assign clr_en_s = 1'b0;
`endif

  // A LOAD in the same enabled cycle as a pair applies to that pair
  always_comb begin
    a_addr_s = x_r;
    a_pal_s  = pal_r;
    if (LOAD) begin
      a_addr_s = X_START;
      a_pal_s  = PAL;
    end else begin
      a_addr_s = x_r;
      a_pal_s  = pal_r;
    end
  end

  // Sequencer state register; reset drops a pending B write
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sequencer next-state logic
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (pair_go_s) begin
          state_nxt_s = ST_WRB;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRB:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Sequencer outputs: the single draw-side write strobe for A or B
  always_comb begin
    wr_en_s   = 1'b0;
    wr_sel_s  = draw_sel_r;
    wr_addr_s = a_addr_s;
    wr_data_s = {a_pal_s, GAD};
    case (state_r)
      ST_IDLE: begin
        wr_en_s   = pair_go_s & DOTA & ~RST;
        wr_sel_s  = draw_sel_r;
        wr_addr_s = a_addr_s;
        wr_data_s = {a_pal_s, GAD};
      end
      ST_WRB: begin
        wr_en_s   = b_dot_r & ~RST;
        wr_sel_s  = b_sel_r;
        wr_addr_s = b_addr_r;
        wr_data_s = b_data_r;
      end
      default: begin
        wr_en_s   = 1'b0;
        wr_sel_s  = draw_sel_r;
        wr_addr_s = a_addr_s;
        wr_data_s = {a_pal_s, GAD};
      end
    endcase
  end

  // Draw-side registers: X counter, palette, buffer select, latched pixel B
  always_ff @(posedge CLK) begin
    if (RST) begin
      x_r        <= {XW{1'b0}};
      pal_r      <= {PW{1'b0}};
      draw_sel_r <= 1'b0;
      b_addr_r   <= {XW{1'b0}};
      b_data_r   <= {DW{1'b0}};
      b_dot_r    <= 1'b0;
      b_sel_r    <= 1'b0;
    end else begin
      if (pair_go_s) begin
        x_r      <= a_addr_s + X_TWO;
        b_addr_r <= a_addr_s + X_ONE;
        b_data_r <= {a_pal_s, GBD};
        b_dot_r  <= DOTB;
        b_sel_r  <= draw_sel_r;
      end else if (LOAD) begin
        x_r <= X_START;
      end
      if (LOAD) begin
        pal_r <= PAL;
      end
      if (LINE_START) begin
        draw_sel_r <= ~draw_sel_r;
      end
    end
  end

  // Display read; uses the pre-toggle select and sees pre-clear data
  always_ff @(posedge CLK) begin
    if (RST) begin
      RD_DATA <= {DW{1'b0}};
    end else if (RD_EN) begin
      if (draw_sel_r) begin
        RD_DATA <= buf0_r[RD_ADDR];
      end else begin
        RD_DATA <= buf1_r[RD_ADDR];
      end
    end
  end

  // Buffer 0 writes: display-side clear first, so a draw write to the same
  // address (late B after a swap) takes priority
  always_ff @(posedge CLK) begin
    if (clr_en_s && draw_sel_r) begin
      buf0_r[RD_ADDR] <= {DW{1'b0}};
    end
    if (wr_en_s && !wr_sel_s) begin
      buf0_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Buffer 1 writes: same ordering as buffer 0
  always_ff @(posedge CLK) begin
    if (clr_en_s && !draw_sel_r) begin
      buf1_r[RD_ADDR] <= {DW{1'b0}};
    end
    if (wr_en_s && wr_sel_s) begin
      buf1_r[wr_addr_s] <= wr_data_s;
    end
  end

endmodule
